// File: rtl/shift_seq_if.sv
// Start/done handshake and operand/result bus between the control unit and the
// multi-cycle shifter.
interface shift_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;
   logic [2:0]       op_en;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] op_out;

   modport master (
      output start, op_x, op_y, op_en,
      input  busy, done, err, op_out
   );

   modport slave (
      input  start, op_x, op_y, op_en,
      output busy, done, err, op_out
   );
endinterface

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: shifts a WIDTH-bit operand one position per clock
// (SLL/SRL/SRA) by an amount of 0..WIDTH-1 and hands back the result with a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; operands sampled here only
//   SHIFT | one bit per clock until cnt reaches zero
//   DONE  | one-cycle done/err pulse, op_out valid
module shift_seq_unit #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input logic        clk,
   input logic        rst,
   shift_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SLL = 2'b01;
   localparam logic [1:0] MODE_SRL = 2'b10;
   localparam logic [1:0] MODE_SRA = 2'b11;

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   sr_q,     sr_d;
   logic [SHAMT_W-1:0] cnt_q,    cnt_d;
   logic [1:0]         mode_q,   mode_d;
   logic               err_q,    err_d;
   logic [WIDTH-1:0]   op_out_q, op_out_d;

   logic [WIDTH-1:0]   src_data;
   logic [SHAMT_W-1:0] src_amt;
   logic [WIDTH-1:0]   sr_shifted;

   always_comb begin
      src_data = bus.op_en[2] ? bus.op_y : bus.op_x;
      src_amt  = bus.op_en[2] ? bus.op_x[SHAMT_W-1:0] : bus.op_y[SHAMT_W-1:0];
   end

   always_comb begin
      sr_shifted = sr_q;
      case (mode_q)
         MODE_SLL: sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
         MODE_SRL: sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
         MODE_SRA: sr_shifted = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
         default:  sr_shifted = sr_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      err_d    = err_q;
      op_out_d = op_out_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mode_d = bus.op_en[1:0];
               err_d  = (bus.op_en[1:0] == 2'b00);
               cnt_d  = src_amt;
               sr_d   = src_data;
               if (bus.op_en[1:0] == 2'b00) begin
                  sr_d     = '0;
                  op_out_d = '0;
                  state_d  = DONE;
               end else if (src_amt == '0) begin
                  op_out_d = src_data;
                  state_d  = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            sr_d  = sr_shifted;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               op_out_d = sr_shifted;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         mode_q   <= '0;
         err_q    <= 1'b0;
         op_out_q <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
         op_out_q <= op_out_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.err    = (state_q == DONE) && err_q;
   assign bus.op_out = op_out_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_shift_seq_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   shift_seq_if #(.WIDTH(16)) ifc ();

   shift_seq_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Transaction model: result computed in one step with shift operators,
   // done scheduled 'amount' cycles after acceptance.
   logic        m_valid = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_done  = 1'b0;
   logic        m_err   = 1'b0;
   logic [15:0] m_out   = '0;
   logic        p_err   = 1'b0;
   logic [15:0] p_res   = '0;
   int          m_left  = 0;

   always @(posedge clk) begin
      logic [15:0] data;
      int          amt;
      if (rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_err   = 1'b0;
         m_out   = '0;
         m_left  = 0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_err  = 1'b0;
         m_busy = 1'b0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_err  = p_err;
            m_out  = p_res;
         end
      end else if (ifc.start) begin
         data  = ifc.op_en[2] ? ifc.op_y : ifc.op_x;
         amt   = int'(ifc.op_en[2] ? ifc.op_x : ifc.op_y) % 16;
         p_err = (ifc.op_en[1:0] == 2'b00);
         case (ifc.op_en[1:0])
            2'b01:   p_res = data << amt;
            2'b10:   p_res = data >> amt;
            2'b11:   p_res = $unsigned($signed(data) >>> amt);
            default: p_res = 16'h0000;
         endcase
         m_busy = 1'b1;
         m_left = p_err ? 0 : amt;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_err  = p_err;
            m_out  = p_res;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_busy",   ifc.busy,   m_busy);
         check("cyc_done",   ifc.done,   m_done);
         check("cyc_err",    ifc.err,    m_err);
         check("cyc_op_out", ifc.op_out, m_out);
      end
   end

   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [2:0] en,
                         input logic [15:0] eo, input logic ee, input int el, input string nm);
      int lat;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.op_x  = x;
      ifc.op_y  = y;
      ifc.op_en = en;
      @(negedge clk);
      ifc.start = 1'b0;
      lat = 1;
      while (!ifc.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, lat, el);
      check({nm, "_op_out"}, ifc.op_out, eo);
      check({nm, "_err"}, ifc.err, ee);
      check({nm, "_model"}, m_out, eo);
      @(negedge clk);
      check({nm, "_busy_after"}, ifc.busy, 1'b0);
   endtask

   initial begin
      int busy_cnt;
      int done_seen;
      int lat;
      ifc.start = 1'b0;
      ifc.op_x  = '0;
      ifc.op_y  = '0;
      ifc.op_en = '0;

      // reset then idle
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", ifc.busy, 1'b0);
      check("rst_done", ifc.done, 1'b0);
      check("rst_err", ifc.err, 1'b0);
      check("rst_op_out", ifc.op_out, 16'h0000);
      repeat (10) @(negedge clk);
      check("idle_op_out", ifc.op_out, 16'h0000);
      check("idle_busy", ifc.busy, 1'b0);

      // SLL by 4 with busy-cycle count
      @(negedge clk);
      ifc.start = 1'b1; ifc.op_x = 16'h00F1; ifc.op_y = 16'h0004; ifc.op_en = 3'b001;
      @(negedge clk);
      ifc.start = 1'b0;
      busy_cnt = 0;
      lat = 1;
      while (ifc.busy && busy_cnt < 40) begin
         if (ifc.done) check("sll4_latency", lat, 5);
         busy_cnt++;
         lat++;
         @(negedge clk);
      end
      check("sll4_busy_cycles", busy_cnt, 5);
      check("sll4_op_out", ifc.op_out, 16'h0F10);

      run_op(16'h000F, 16'h8000, 3'b111, 16'hFFFF, 1'b0, 16, "sra15");
      run_op(16'h000F, 16'h8000, 3'b110, 16'h0001, 1'b0, 16, "srl15");
      run_op(16'h1234, 16'h0000, 3'b010, 16'h1234, 1'b0, 1, "srl0");
      run_op(16'h1234, 16'h0011, 3'b010, 16'h091A, 1'b0, 2, "srl_mod");
      run_op(16'h1234, 16'h0003, 3'b100, 16'h0000, 1'b1, 1, "illegal");
      run_op(16'h0001, 16'h000F, 3'b001, 16'h8000, 1'b0, 16, "sll15");

      // start during SHIFT is ignored
      @(negedge clk);
      ifc.start = 1'b1; ifc.op_x = 16'h0001; ifc.op_y = 16'h000F; ifc.op_en = 3'b001;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (2) @(negedge clk);
      ifc.start = 1'b1; ifc.op_x = 16'hFFFF; ifc.op_y = 16'h0001; ifc.op_en = 3'b010;
      @(negedge clk);
      ifc.start = 1'b0;
      lat = 4;
      while (!ifc.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("ignored_latency", lat, 16);
      check("ignored_op_out", ifc.op_out, 16'h8000);
      @(negedge clk);
      check("ignored_no_requeue", ifc.busy, 1'b0);

      // reset mid-shift
      @(negedge clk);
      ifc.start = 1'b1; ifc.op_x = 16'h0003; ifc.op_y = 16'h000A; ifc.op_en = 3'b001;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", ifc.busy, 1'b0);
      check("abort_op_out", ifc.op_out, 16'h0000);
      done_seen = 0;
      repeat (15) begin
         if (ifc.done) done_seen++;
         @(negedge clk);
      end
      check("abort_no_done", done_seen, 0);
      run_op(16'h0003, 16'h000A, 3'b001, 16'h0C00, 1'b0, 11, "after_abort");

      // randomized traffic, model checked every cycle
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 149) == 0);
         ifc.start = ($urandom_range(0, 2) == 0);
         ifc.op_x  = 16'($urandom);
         ifc.op_y  = 16'($urandom);
         ifc.op_en = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      rst = 1'b0;
      ifc.start = 1'b0;
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
